// File: rtl/block_xfer_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list, one memory beat per register.
// Optional mem_abort/aborted handshake is built when BLOCK_XFER_ABORT_EN is defined.
module block_xfer_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              is_load,
   input  logic [15:0]       reg_list,
   input  logic [3:0]        base_reg,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              up,
   input  logic              pre,
   input  logic              wback,
   output logic [3:0]        read_reg_num,
   output logic              reg_read,
   input  logic [DATA_W-1:0] read_data,
   output logic [3:0]        write_reg,
   output logic [DATA_W-1:0] write_data,
   output logic              regwrite,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
`ifdef BLOCK_XFER_ABORT_EN
   input  logic              mem_abort,
   output logic              aborted,
`endif
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WB, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [15:0]       list_q;
   logic [ADDR_W-1:0] base_q, addr_q, final_base_q;
   logic [3:0]        base_reg_q;
   logic              is_load_q, up_q, pre_q, wback_q, wb_en_q;

   logic [3:0]        cur_reg;
   logic [15:0]       list_rest;
   logic [ADDR_W-1:0] span;
   logic              abort_hit, beat_ack;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
      return n;
   endfunction

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
      return r;
   endfunction

   assign cur_reg   = lowest_set(list_q);
   assign list_rest = list_q & (list_q - 16'd1);
   assign span      = ADDR_W'(popcount16(list_q)) << 2;

`ifdef BLOCK_XFER_ABORT_EN
   logic abort_q;
   // An abort wins over an ack in the same cycle, so the beat is never committed.
   assign abort_hit = mem_abort && (state_q == S_XFER);
`else
   assign abort_hit = 1'b0;
`endif
   assign beat_ack = (state_q == S_XFER) && mem_ack && !abort_hit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: state_d = (list_q == '0) ? S_DONE : S_XFER;
         S_XFER: begin
            if (abort_hit)
               state_d = S_DONE;
            else if (mem_ack && list_rest == '0)
               state_d = wb_en_q ? S_WB : S_DONE;
         end
         S_WB:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         list_q       <= '0;
         base_q       <= '0;
         addr_q       <= '0;
         final_base_q <= '0;
         base_reg_q   <= '0;
         is_load_q    <= 1'b0;
         up_q         <= 1'b0;
         pre_q        <= 1'b0;
         wback_q      <= 1'b0;
         wb_en_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               list_q     <= reg_list;
               base_q     <= base_addr;
               base_reg_q <= base_reg;
               is_load_q  <= is_load;
               up_q       <= up;
               pre_q      <= pre;
               wback_q    <= wback;
            end
            S_SETUP: begin
               // Lowest register always sits at the lowest address, whatever the direction.
               unique case ({up_q, pre_q})
                  2'b10:   addr_q <= base_q;
                  2'b11:   addr_q <= base_q + ADDR_W'(4);
                  2'b00:   addr_q <= base_q - span + ADDR_W'(4);
                  default: addr_q <= base_q - span;
               endcase
               final_base_q <= up_q ? base_q + span : base_q - span;
               wb_en_q      <= wback_q && !(is_load_q && list_q[base_reg_q]);
            end
            S_XFER: if (beat_ack) begin
               list_q <= list_rest;
               addr_q <= addr_q + ADDR_W'(4);
            end
            default: ;
         endcase
      end
   end

`ifdef BLOCK_XFER_ABORT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                  abort_q <= 1'b0;
      else if (abort_hit)          abort_q <= 1'b1;
      else if (state_q == S_DONE)  abort_q <= 1'b0;
   end
   assign aborted = (state_q == S_DONE) && abort_q;
`endif

   always_comb begin
      read_reg_num = '0;
      reg_read     = 1'b0;
      write_reg    = '0;
      write_data   = '0;
      regwrite     = 1'b0;
      mem_req      = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      unique case (state_q)
         S_XFER: begin
            mem_req   = 1'b1;
            mem_addr  = addr_q;
            mem_write = !is_load_q;
            if (!is_load_q) begin
               reg_read     = 1'b1;
               read_reg_num = cur_reg;
               mem_wdata    = read_data;
            end else if (beat_ack) begin
               regwrite   = 1'b1;
               write_reg  = cur_reg;
               write_data = mem_rdata;
            end
         end
         S_WB: begin
            regwrite   = 1'b1;
            write_reg  = base_reg_q;
            write_data = DATA_W'(final_base_q);
         end
         default: ;
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);

endmodule

// File: doc/block_xfer_sequencer.md
Name: block_xfer_sequencer

Overview:
- Initiator side of the register-file read/write port: walks a 16-bit register list for ARM LDM/STM block transfers.
- Drives register numbers and regwrite into the 16-entry register file, and a word-per-beat req/ack memory interface.
- Sits between the instruction decoder (start plus decoded fields) and the register file and data memory.

Parameters:
- DATA_W, 32, register and memory data width.
- ADDR_W, 32, memory address width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- is_load  input  1  1 = LDM (memory to registers), 0 = STM.
- reg_list  input  16  bit n set = transfer Rn.
- base_reg  input  4  base register number.
- base_addr  input  ADDR_W  current value of the base register.
- up  input  1  U bit: 1 = increment, 0 = decrement.
- pre  input  1  P bit: 1 = pre-index, 0 = post-index.
- wback  input  1  W bit: write the final base back.
- read_reg_num  output  4  register-file read select (STM).
- reg_read  output  1  read strobe.
- read_data  input  DATA_W  combinational register-file read data.
- write_reg  output  4  register-file write select.
- write_data  output  DATA_W  register-file write data.
- regwrite  output  1  register-file write enable.
- mem_req  output  1  memory request.
- mem_write  output  1  1 = store.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  DATA_W  store data.
- mem_rdata  input  DATA_W  load data, valid with mem_ack.
- mem_ack  input  1  beat complete.
- busy  output  1  high from SETUP until DONE, inclusive.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; all outputs 0; internal list, address and count registers cleared. Reset mid-transfer abandons the operation; no further writes occur.
- IDLE: on start, latch all inputs, go to SETUP. start is ignored while busy.
- SETUP (1 cycle):
  - cnt = popcount(reg_list).
  - Start address: IA (up, !pre) = base; IB (up, pre) = base+4; DA (!up, !pre) = base-4*cnt+4; DB (!up, pre) = base-4*cnt.
  - final_base = base ± 4*cnt, computed modulo 2^ADDR_W (wraps silently).
  - Empty list: skip directly to DONE; no memory or register activity, no writeback.
- XFER:
  - Current register = lowest set bit of the remaining list. Addresses always ascend: lowest register at the lowest address.
  - mem_req = 1 and mem_addr, mem_write held stable until mem_ack.
  - STM: read_reg_num = current register, reg_read = 1, mem_wdata = read_data (combinational).
  - LDM: in the cycle mem_ack = 1, regwrite = 1, write_reg = current register, write_data = mem_rdata, so the register file captures on the same edge.
  - On ack: clear the bit, add 4 to the address. When the last bit clears, go to WB if wback, else DONE.
  - Minimum one cycle per beat.
- WB (1 cycle): regwrite = 1, write_reg = base_reg, write_data = final_base.
  - Suppressed for LDM when base_reg is in the list; the loaded value wins.
  - STM with base in the list stores the original base value.
- DONE: done = 1 for one cycle, busy = 1, then IDLE. A start in the DONE cycle is ignored.
- mem_ack outside XFER is ignored.

Optional Feature:
- Macro: BLOCK_XFER_ABORT_EN.
- Defined:
  - Adds input mem_abort (1 bit) and output aborted (1 bit, reset 0).
  - mem_abort high with mem_req in XFER ends the transfer. That beat's regwrite is suppressed, writeback is skipped, and aborted and done pulse together for one cycle before IDLE.
  - mem_abort has priority over a simultaneous mem_ack.
- Undefined: no such ports; every beat waits for mem_ack indefinitely.

Test Plan:
- STM IA, list=0x000E, base R13=0x1000, wback=1, ack every cycle: stores R1, R2, R3 to 0x1000/0x1004/0x1008, then R13 written 0x100C, done.
- LDM DB, list=0x8001, base=0x2000, wback=0: loads 0x1FF8 into R0 and 0x1FFC into R15, no base write, 1 cycle per beat with ack held high.
- LDM IA, base_reg=R2, list=0x0004, wback=1, mem_rdata=0xDEADBEEF: R2=0xDEADBEEF, no writeback cycle.
- Empty list with start: done asserted 2 cycles after start; mem_req and regwrite never asserted.
- mem_ack delayed 3 cycles per beat with reset pulled low during the 2nd beat: outputs drop to 0 immediately; a following start runs cleanly from IDLE.
- Abort (BLOCK_XFER_ABORT_EN), LDM list=0x0007, mem_abort on the 2nd beat: only R0 is written, aborted and done pulse together, no writeback.
